rob: RTL and testbench

- Reorder buffer for the 2-way out-of-order core.
- Sits directly downstream of rat. It takes each renamed instruction (architectural dest, plus physical dest from rat's pdest_idx_out) at dispatch and holds it in program order.
- It produces the retire, retire_dest_idx_in and retire_pdest_idx_in stream that commits mappings into the rrat. Its flush output drives rat's flush on a mispredicted branch.

---
 rtl/rob.sv | 144 ++++++++++++++
 tb/tb_rob.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer for the 2-way out-of-order core: holds renamed instructions in
// program order, retires up to two completed entries per cycle, flushes on mispredict.
module rob #(
    parameter int unsigned SCALAR  = 2,
    parameter int unsigned ROB_SZ  = 32,
    parameter int unsigned ROB_IDX = 5,
    parameter int unsigned ARF_IDX = 5,
    parameter int unsigned PRF_IDX = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SCALAR-1:0]           dispatch,
    input  logic [SCALAR*ARF_IDX-1:0]   dispatch_dest_idx,
    input  logic [SCALAR*PRF_IDX-1:0]   dispatch_pdest_idx,
    input  logic [SCALAR-1:0]           complete,
    input  logic [SCALAR*ROB_IDX-1:0]   complete_rob_idx,
    input  logic [SCALAR-1:0]           complete_mispred,
    output logic [SCALAR*ROB_IDX-1:0]   rob_idx_out,
    output logic                        stall,
    output logic                        empty,
    output logic [SCALAR-1:0]           retire,
    output logic [SCALAR*ARF_IDX-1:0]   retire_dest_idx,
    output logic [SCALAR*PRF_IDX-1:0]   retire_pdest_idx,
    output logic                        flush
);

    logic [ROB_SZ-1:0]  valid_q, valid_d;
    logic [ROB_SZ-1:0]  done_q, done_d;
    logic [ROB_SZ-1:0]  mispred_q, mispred_d;
    logic [ARF_IDX-1:0] dest_q [ROB_SZ];
    logic [ARF_IDX-1:0] dest_d [ROB_SZ];
    logic [PRF_IDX-1:0] pdest_q [ROB_SZ];
    logic [PRF_IDX-1:0] pdest_d [ROB_SZ];
    logic [ROB_IDX-1:0] head_q, head_d;
    logic [ROB_IDX-1:0] tail_q, tail_d;
    logic [ROB_IDX:0]   count_q, count_d;

    logic [ROB_IDX-1:0] head_p1;
    logic [ROB_IDX-1:0] tag0, tag1;
    logic               retire_0, retire_1;
    logic               accept;
    logic [ROB_IDX:0]   n_disp, n_ret;

    // Dispatch handshake: dispatch[i] is a valid request; it is taken at the
    // posedge only when stall==0 and flush==0, otherwise it is dropped (not held).
    always_comb begin
        head_p1  = head_q + ROB_IDX'(1);
        tag0     = tail_q;
        tag1     = tail_q + ROB_IDX'(dispatch[0]);
        retire_0 = valid_q[head_q] & done_q[head_q];
        retire_1 = retire_0 & ~mispred_q[head_q] & valid_q[head_p1] & done_q[head_p1];
        flush    = retire_0 & mispred_q[head_q];
        stall    = count_q > (ROB_IDX+1)'(ROB_SZ - 2);
        empty    = (count_q == '0);
        accept   = ~stall & ~flush;
        n_disp   = accept ? ((ROB_IDX+1)'(dispatch[0]) + (ROB_IDX+1)'(dispatch[1])) : '0;
        n_ret    = (ROB_IDX+1)'(retire_0) + (ROB_IDX+1)'(retire_1);

        rob_idx_out      = {tag1, tag0};
        retire           = {retire_1, retire_0};
        retire_dest_idx  = {dest_q[head_p1], dest_q[head_q]};
        retire_pdest_idx = {pdest_q[head_p1], pdest_q[head_q]};
    end

    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        mispred_d = mispred_q;
        dest_d    = dest_q;
        pdest_d   = pdest_q;
        head_d    = head_q + ROB_IDX'(n_ret);
        tail_d    = tail_q + ROB_IDX'(n_disp);
        count_d   = count_q + n_disp - n_ret;

        // Completion applied before retire clears so a late completion to a
        // retiring slot cannot leave a stale done bit; way1 wins on a tag clash.
        for (int i = 0; i < SCALAR; i++) begin
            if (complete[i] && valid_q[complete_rob_idx[i*ROB_IDX +: ROB_IDX]]) begin
                done_d[complete_rob_idx[i*ROB_IDX +: ROB_IDX]]    = 1'b1;
                mispred_d[complete_rob_idx[i*ROB_IDX +: ROB_IDX]] = complete_mispred[i];
            end
        end

        if (retire_0) begin
            valid_d[head_q]   = 1'b0;
            done_d[head_q]    = 1'b0;
            mispred_d[head_q] = 1'b0;
        end
        if (retire_1) begin
            valid_d[head_p1]   = 1'b0;
            done_d[head_p1]    = 1'b0;
            mispred_d[head_p1] = 1'b0;
        end

        if (accept && dispatch[0]) begin
            valid_d[tag0]   = 1'b1;
            done_d[tag0]    = 1'b0;
            mispred_d[tag0] = 1'b0;
            dest_d[tag0]    = dispatch_dest_idx[0 +: ARF_IDX];
            pdest_d[tag0]   = dispatch_pdest_idx[0 +: PRF_IDX];
        end
        if (accept && dispatch[1]) begin
            valid_d[tag1]   = 1'b1;
            done_d[tag1]    = 1'b0;
            mispred_d[tag1] = 1'b0;
            dest_d[tag1]    = dispatch_dest_idx[ARF_IDX +: ARF_IDX];
            pdest_d[tag1]   = dispatch_pdest_idx[PRF_IDX +: PRF_IDX];
        end

        if (flush) begin
            valid_d   = '0;
            done_d    = '0;
            mispred_d = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q   <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            done_q    <= done_d;
            mispred_q <= mispred_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        dest_q  <= dest_d;
        pdest_q <= pdest_d;
    end

endmodule

// File: tb/tb_rob.sv
// Directed testbench for rob: reset, fill/stall, in-order retire, wrap, mispredict flush.
module tb_rob;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  dispatch;
    logic [9:0]  dispatch_dest_idx;
    logic [13:0] dispatch_pdest_idx;
    logic [1:0]  complete;
    logic [9:0]  complete_rob_idx;
    logic [1:0]  complete_mispred;
    logic [9:0]  rob_idx_out;
    logic        stall;
    logic        empty;
    logic [1:0]  retire;
    logic [9:0]  retire_dest_idx;
    logic [13:0] retire_pdest_idx;
    logic        flush;

    int n_checks = 0;
    int n_fails  = 0;
    logic [6:0] exp_q[$];

    rob dut (
        .clk                (clk),
        .reset              (reset),
        .dispatch           (dispatch),
        .dispatch_dest_idx  (dispatch_dest_idx),
        .dispatch_pdest_idx (dispatch_pdest_idx),
        .complete           (complete),
        .complete_rob_idx   (complete_rob_idx),
        .complete_mispred   (complete_mispred),
        .rob_idx_out        (rob_idx_out),
        .stall              (stall),
        .empty              (empty),
        .retire             (retire),
        .retire_dest_idx    (retire_dest_idx),
        .retire_pdest_idx   (retire_pdest_idx),
        .flush              (flush)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [1:0] d, input int dst0, input int pd0,
                            input int dst1, input int pd1);
        dispatch           = d;
        dispatch_dest_idx  = {5'(dst1), 5'(dst0)};
        dispatch_pdest_idx = {7'(pd1), 7'(pd0)};
    endtask

    task automatic set_cmp(input logic [1:0] c, input int t0, input int t1,
                           input logic [1:0] m);
        complete         = c;
        complete_rob_idx = {5'(t1), 5'(t0)};
        complete_mispred = m;
    endtask

    task automatic idle();
        set_disp(2'b00, 0, 0, 0, 0);
        set_cmp(2'b00, 0, 0, 2'b00);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        step();
        step();
        set_disp(2'b01, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rob_idx_out !== {5'd1, 5'd0}) begin n_fails++; $display("FAIL reset_tag_d0: got %h expected %h", rob_idx_out, {5'd1, 5'd0}); end
        idle();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (empty !== 1'b1) begin n_fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
            n_checks++;
            if (stall !== 1'b0) begin n_fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
            n_checks++;
            if (retire !== 2'b00) begin n_fails++; $display("FAIL reset_retire: got %b expected 00", retire); end
            n_checks++;
            if (flush !== 1'b0) begin n_fails++; $display("FAIL reset_flush: got %b expected 0", flush); end
            n_checks++;
            if (rob_idx_out !== 10'h000) begin n_fails++; $display("FAIL reset_tag_idle: got %h expected 000", rob_idx_out); end
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            n_checks++;
            if (stall !== 1'b0) begin n_fails++; $display("FAIL fill_stall_lo c=%0d: got %b expected 0", c, stall); end
            set_disp(2'b11, 2*c, 32+2*c, 2*c+1, 33+2*c);
            #1;
            n_checks++;
            if (rob_idx_out !== {5'(2*c+1), 5'(2*c)})
                begin n_fails++; $display("FAIL fill_tag c=%0d: got %h expected %h", c, rob_idx_out, {5'(2*c+1), 5'(2*c)}); end
            step();
        end
        idle();
        n_checks++;
        if (stall !== 1'b1) begin n_fails++; $display("FAIL fill_stall_hi: got %b expected 1", stall); end
        n_checks++;
        if (empty !== 1'b0) begin n_fails++; $display("FAIL fill_empty: got %b expected 0", empty); end
        n_checks++;
        if (retire !== 2'b00) begin n_fails++; $display("FAIL fill_retire: got %b expected 00", retire); end
        // 17th dispatch with distinct payload must be dropped
        set_disp(2'b11, 30, 100, 31, 101);
        #1;
        n_checks++;
        if (rob_idx_out !== {5'd1, 5'd0}) begin n_fails++; $display("FAIL full_tag: got %h expected %h", rob_idx_out, {5'd1, 5'd0}); end
        step();
        idle();
        n_checks++;
        if (stall !== 1'b1) begin n_fails++; $display("FAIL full_stall: got %b expected 1", stall); end
        set_cmp(2'b01, 1, 0, 2'b00);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b00) begin n_fails++; $display("FAIL order_wait: got %b expected 00", retire); end
        set_cmp(2'b01, 0, 0, 2'b00);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b11) begin n_fails++; $display("FAIL order_retire: got %b expected 11", retire); end
        n_checks++;
        if (retire_dest_idx !== {5'd1, 5'd0}) begin n_fails++; $display("FAIL order_dest: got %h expected %h", retire_dest_idx, {5'd1, 5'd0}); end
        n_checks++;
        if (retire_pdest_idx !== {7'd33, 7'd32}) begin n_fails++; $display("FAIL order_pdest: got %h expected %h", retire_pdest_idx, {7'd33, 7'd32}); end
        step();
        n_checks++;
        if (retire !== 2'b00) begin n_fails++; $display("FAIL head2_retire: got %b expected 00", retire); end
        n_checks++;
        if (stall !== 1'b0) begin n_fails++; $display("FAIL head2_stall: got %b expected 0", stall); end
        set_cmp(2'b11, 2, 3, 2'b00);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b11 || retire_dest_idx !== {5'd3, 5'd2})
            begin n_fails++; $display("FAIL head2_next: got %b/%h expected 11/%h", retire, retire_dest_idx, {5'd3, 5'd2}); end
    endtask

    task automatic test_wrap();
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 44; k++) begin
            for (int w = 0; w < 2; w++) begin
                if (retire[w]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fails++; $display("FAIL wrap_extra k=%0d w=%0d: got retire, expected none", k, w);
                    end else begin
                        logic [6:0] e;
                        e = exp_q.pop_front();
                        if (retire_pdest_idx[w*7 +: 7] !== e)
                            begin n_fails++; $display("FAIL wrap_pdest k=%0d w=%0d: got %0d expected %0d", k, w, retire_pdest_idx[w*7 +: 7], e); end
                    end
                end
            end
            idle();
            if (k < 40) set_disp(2'b01, k % 32, k, 0, 0);
            if (k > 0 && k <= 40) set_cmp(2'b01, (k-1) % 32, 0, 2'b00);
            #1;
            if (k < 40) begin
                n_checks++;
                if (rob_idx_out[4:0] !== 5'(k % 32))
                    begin n_fails++; $display("FAIL wrap_tag k=%0d: got %0d expected %0d", k, rob_idx_out[4:0], k % 32); end
                exp_q.push_back(7'(k));
            end
            step();
        end
        idle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fails++; $display("FAIL wrap_drain: got %0d left expected 0", exp_q.size()); end
        n_checks++;
        if (empty !== 1'b1) begin n_fails++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_mispred();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_disp(2'b11, 2*c, 40+2*c, 2*c+1, 41+2*c);
            step();
        end
        idle();
        set_cmp(2'b11, 0, 1, 2'b00);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b11 || retire_dest_idx !== {5'd1, 5'd0} || flush !== 1'b0)
            begin n_fails++; $display("FAIL mp_cycle_a: got %b/%h/%b expected 11/%h/0", retire, retire_dest_idx, flush, {5'd1, 5'd0}); end
        set_cmp(2'b11, 2, 3, 2'b00);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b11 || retire_pdest_idx !== {7'd43, 7'd42})
            begin n_fails++; $display("FAIL mp_cycle_b: got %b/%h expected 11/%h", retire, retire_pdest_idx, {7'd43, 7'd42}); end
        set_cmp(2'b11, 4, 5, 2'b01);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b01) begin n_fails++; $display("FAIL mp_c_retire: got %b expected 01", retire); end
        n_checks++;
        if (flush !== 1'b1) begin n_fails++; $display("FAIL mp_c_flush: got %b expected 1", flush); end
        n_checks++;
        if (retire_dest_idx[4:0] !== 5'd4) begin n_fails++; $display("FAIL mp_c_dest: got %0d expected 4", retire_dest_idx[4:0]); end
        set_disp(2'b11, 9, 99, 10, 100);
        step();
        idle();
        n_checks++;
        if (empty !== 1'b1) begin n_fails++; $display("FAIL mp_d_empty: got %b expected 1", empty); end
        n_checks++;
        if (retire !== 2'b00 || flush !== 1'b0) begin n_fails++; $display("FAIL mp_d_retire: got %b/%b expected 00/0", retire, flush); end
        set_disp(2'b01, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (rob_idx_out !== {5'd1, 5'd0}) begin n_fails++; $display("FAIL mp_d_tail: got %h expected %h", rob_idx_out, {5'd1, 5'd0}); end
        idle();
    endtask

    task automatic test_same_tag();
        do_reset();
        set_disp(2'b11, 3, 10, 4, 11);
        step();
        idle();
        set_cmp(2'b11, 0, 0, 2'b01);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b01 || flush !== 1'b0) begin n_fails++; $display("FAIL same_tag: got %b/%b expected 01/0", retire, flush); end
        step();
        set_cmp(2'b01, 2, 0, 2'b00);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b00) begin n_fails++; $display("FAIL inv_cmp_wait: got %b expected 00", retire); end
        set_disp(2'b01, 5, 12, 0, 0);
        #1;
        n_checks++;
        if (rob_idx_out[4:0] !== 5'd2) begin n_fails++; $display("FAIL inv_tag: got %0d expected 2", rob_idx_out[4:0]); end
        step();
        idle();
        set_cmp(2'b01, 1, 0, 2'b00);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b01 || retire_pdest_idx[6:0] !== 7'd11)
            begin n_fails++; $display("FAIL inv_cmp_ignored: got %b/%0d expected 01/11", retire, retire_pdest_idx[6:0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_disp(2'b11, c, c, c, c);
            step();
        end
        idle();
        set_cmp(2'b11, 0, 1, 2'b00);
        step();
        idle();
        n_checks++;
        if (retire !== 2'b11) begin n_fails++; $display("FAIL rmid_pre: got %b expected 11", retire); end
        reset = 1'b0;
        set_disp(2'b11, 7, 7, 8, 8);
        step();
        n_checks++;
        if (empty !== 1'b1 || stall !== 1'b0) begin n_fails++; $display("FAIL rmid_empty: got %b/%b expected 1/0", empty, stall); end
        n_checks++;
        if (retire !== 2'b00 || flush !== 1'b0) begin n_fails++; $display("FAIL rmid_retire: got %b/%b expected 00/0", retire, flush); end
        n_checks++;
        if (rob_idx_out !== {5'd1, 5'd0}) begin n_fails++; $display("FAIL rmid_tag: got %h expected %h", rob_idx_out, {5'd1, 5'd0}); end
        idle();
        reset = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_wrap();
        test_mispred();
        test_same_tag();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
